xbar_req_router: RTL and testbench

Parametrised request crossbar between NUM_CH requester channels and NUM_BANK cache banks. It decodes the target bank from each request's line address, runs an independent round-robin arbiter per bank, and drives each bank's HTU interface from a registered output slot with a valid/ready handshake. It replaces the fixed 3-channel/4-bank request path of the cross-bar top, and adds two things that path does not have: selectable bank hashing and back-to-back throughput under backpressure.

---
 rtl/xbar_req_router_if.sv | 45 ++++
 rtl/xbar_req_router.sv | 116 +++++++++++
 tb/tb_xbar_req_router.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/xbar_req_router_if.sv
// Request crossbar bundle: requester channels on one side,
// per-bank HTU slots on the other.
interface xbar_req_router_if #(
  parameter int NUM_CH   = 3,
  parameter int NUM_BANK = 4,
  parameter int ADDR_W   = 28,
  parameter int OP_W     = 3
);
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]          ch_req_valid_i;
  logic [NUM_CH-1:0]          ch_req_allowIn_o;
  logic [NUM_CH*OP_W-1:0]     ch_req_op_i;
  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i;
  logic [NUM_BANK-1:0]        bank_htu_valid_o;
  logic [NUM_BANK-1:0]        bank_htu_ready_i;
  logic [NUM_BANK*CH_W-1:0]   bank_htu_ch_id_o;
  logic [NUM_BANK*OP_W-1:0]   bank_htu_opcode_o;
  logic [NUM_BANK*ADDR_W-1:0] bank_htu_addr_o;

  modport master (
    output ch_req_valid_i,
    output ch_req_op_i,
    output ch_req_addr_i,
    output bank_htu_ready_i,
    input  ch_req_allowIn_o,
    input  bank_htu_valid_o,
    input  bank_htu_ch_id_o,
    input  bank_htu_opcode_o,
    input  bank_htu_addr_o
  );

  modport slave (
    input  ch_req_valid_i,
    input  ch_req_op_i,
    input  ch_req_addr_i,
    input  bank_htu_ready_i,
    output ch_req_allowIn_o,
    output bank_htu_valid_o,
    output bank_htu_ch_id_o,
    output bank_htu_opcode_o,
    output bank_htu_addr_o
  );
endinterface

// File: rtl/xbar_req_router.sv
// Channel-to-bank request crossbar: bank decode, per-bank
// round-robin arbitration and a registered output slot per bank.
module xbar_req_router #(
  parameter int NUM_CH    = 3,
  parameter int NUM_BANK  = 4,
  parameter int ADDR_W    = 28,
  parameter int OP_W      = 3,
  parameter int BANK_HASH = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  xbar_req_router_if.slave bus
);
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BB = $clog2(NUM_BANK);

  typedef logic [BB-1:0]   bank_t;
  typedef logic [CH_W-1:0] ch_t;

  logic [OP_W-1:0]   op_in   [NUM_CH];
  logic [ADDR_W-1:0] addr_in [NUM_CH];
  bank_t             tgt     [NUM_CH];

  ch_t                 rr_q   [NUM_BANK];
  ch_t                 win    [NUM_BANK];
  int                  best   [NUM_BANK];
  logic [NUM_BANK-1:0] hit;
  logic [NUM_BANK-1:0] acc;
  logic [NUM_BANK-1:0] free;

  logic [NUM_BANK-1:0] v_q;
  ch_t                 id_q   [NUM_BANK];
  logic [OP_W-1:0]     op_q   [NUM_BANK];
  logic [ADDR_W-1:0]   addr_q [NUM_BANK];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      op_in[c]   = bus.ch_req_op_i[c*OP_W +: OP_W];
      addr_in[c] = bus.ch_req_addr_i[c*ADDR_W +: ADDR_W];
      if (BANK_HASH != 0)
        tgt[c] = addr_in[c][BB-1:0]
               ^ addr_in[c][2*BB-1:BB];
      else
        tgt[c] = addr_in[c][BB-1:0];
    end
  end

  // Winner is the candidate at the smallest rotated distance from rr_q.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      win[b]  = '0;
      best[b] = 0;
      hit[b]  = 1'b0;
      free[b] = !v_q[b] || bus.bank_htu_ready_i[b];
      for (int c = 0; c < NUM_CH; c++) begin
        int d;
        d = c - int'(rr_q[b]);
        if (d < 0) d = d + NUM_CH;
        if (bus.ch_req_valid_i[c] &&
            tgt[c] == bank_t'(b) &&
            (!hit[b] || d < best[b])) begin
          hit[b]  = 1'b1;
          best[b] = d;
          win[b]  = ch_t'(c);
        end
      end
      acc[b] = hit[b] && free[b] && rst_i;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      bus.ch_req_allowIn_o[c] =
        bus.ch_req_valid_i[c] &&
        acc[tgt[c]] &&
        (win[tgt[c]] == ch_t'(c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q <= '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        rr_q[b]   <= '0;
        id_q[b]   <= '0;
        op_q[b]   <= '0;
        addr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (acc[b]) begin
          v_q[b]    <= 1'b1;
          id_q[b]   <= win[b];
          op_q[b]   <= op_in[win[b]];
          addr_q[b] <= addr_in[win[b]];
          if (win[b] == ch_t'(NUM_CH - 1))
            rr_q[b] <= '0;
          else
            rr_q[b] <= win[b] + ch_t'(1);
        end else if (bus.bank_htu_ready_i[b]) begin
          v_q[b] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.bank_htu_valid_o = v_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      bus.bank_htu_ch_id_o[b*CH_W +: CH_W]    = id_q[b];
      bus.bank_htu_opcode_o[b*OP_W +: OP_W]   = op_q[b];
      bus.bank_htu_addr_o[b*ADDR_W +: ADDR_W] = addr_q[b];
    end
  end
endmodule

// File: tb/tb_xbar_req_router.sv
// Directed bench for xbar_req_router: reset, parallel accept,
// round-robin wrap, backpressure and bank hashing.
module tb_xbar_req_router;
  localparam int NC = 3;
  localparam int NB = 4;
  localparam int AW = 28;
  localparam int OW = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbar_req_router_if #(NC, NB, AW, OW) b0 ();
  xbar_req_router_if #(NC, NB, AW, OW) b1 ();

  xbar_req_router #(
    .NUM_CH(NC), .NUM_BANK(NB), .ADDR_W(AW),
    .OP_W(OW), .BANK_HASH(0)
  ) u0 (
    .clk_i(clk), .rst_i(rst_n), .bus(b0)
  );

  xbar_req_router #(
    .NUM_CH(NC), .NUM_BANK(NB), .ADDR_W(AW),
    .OP_W(OW), .BANK_HASH(1)
  ) u1 (
    .clk_i(clk), .rst_i(rst_n), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int c, input logic v,
                     input logic [AW-1:0] a,
                     input logic [OW-1:0] op);
    b0.ch_req_valid_i[c]         = v;
    b0.ch_req_addr_i[c*AW +: AW] = a;
    b0.ch_req_op_i[c*OW +: OW]   = op;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NC; c++) drv(c, 1'b0, '0, '0);
  endtask

  logic [2:0] exp_g  [5] = '{3'b001, 3'b010, 3'b100,
                             3'b001, 3'b010};
  logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2,
                             2'd0, 2'd1};

  initial begin
    b0.ch_req_valid_i   = '0;
    b0.ch_req_op_i      = '0;
    b0.ch_req_addr_i    = '0;
    b0.bank_htu_ready_i = '0;
    b1.ch_req_valid_i   = '0;
    b1.ch_req_op_i      = '0;
    b1.ch_req_addr_i    = '0;
    b1.bank_htu_ready_i = 4'hF;

    // reset, with a request already pending
    drv(0, 1'b1, 28'h1, 3'd1);
    tick();
    tick();
    chk("rst_valid", 64'(b0.bank_htu_valid_o), 0);
    chk("rst_allow", 64'(b0.ch_req_allowIn_o), 0);
    chk("rst_id", 64'(b0.bank_htu_ch_id_o), 0);
    chk("rst_op", 64'(b0.bank_htu_opcode_o), 0);
    chk("rst_addr0", 64'(b0.bank_htu_addr_o[0 +: AW]), 0);
    idle_all();
    rst_n = 1'b1;
    #1;

    // parallel, no contention
    b0.bank_htu_ready_i = 4'hF;
    drv(0, 1'b1, 28'h0, 3'd1);
    drv(1, 1'b1, 28'h1, 3'd2);
    drv(2, 1'b1, 28'h2, 3'd3);
    #1;
    chk("par_allow", 64'(b0.ch_req_allowIn_o), 3'b111);
    tick();
    idle_all();
    chk("par_valid", 64'(b0.bank_htu_valid_o), 4'b0111);
    chk("par_id", 64'(b0.bank_htu_ch_id_o), 8'h24);
    chk("par_op", 64'(b0.bank_htu_opcode_o), 12'h0D1);
    for (int b = 0; b < 3; b++)
      chk($sformatf("par_addr%0d", b),
          64'(b0.bank_htu_addr_o[b*AW +: AW]), 64'(b));
    tick();
    chk("par_drain", 64'(b0.bank_htu_valid_o), 0);

    // round-robin with wrap on bank 3
    for (int c = 0; c < NC; c++) drv(c, 1'b1, 28'h3, 3'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_allow%0d", k),
          64'(b0.ch_req_allowIn_o), 64'(exp_g[k]));
      tick();
      chk($sformatf("rr_id%0d", k),
          64'(b0.bank_htu_ch_id_o[3*CW +: CW]),
          64'(exp_id[k]));
      chk($sformatf("rr_v%0d", k),
          64'(b0.bank_htu_valid_o), 4'b1000);
    end
    idle_all();
    tick();
    chk("rr_drain", 64'(b0.bank_htu_valid_o), 0);

    // backpressure on bank 1
    b0.bank_htu_ready_i = 4'b1101;
    drv(1, 1'b1, 28'h5, 3'd5);
    #1;
    chk("bp_allow0", 64'(b0.ch_req_allowIn_o), 3'b010);
    tick();
    drv(1, 1'b1, 28'h9, 3'd6);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_block%0d", k),
          64'(b0.ch_req_allowIn_o), 0);
      tick();
      chk($sformatf("bp_v%0d", k),
          64'(b0.bank_htu_valid_o), 4'b0010);
      chk($sformatf("bp_id%0d", k),
          64'(b0.bank_htu_ch_id_o[1*CW +: CW]), 1);
      chk($sformatf("bp_addr%0d", k),
          64'(b0.bank_htu_addr_o[1*AW +: AW]), 5);
    end
    b0.bank_htu_ready_i = 4'hF;
    #1;
    chk("bp_reload_allow", 64'(b0.ch_req_allowIn_o), 3'b010);
    tick();
    idle_all();
    chk("bp_reload_v", 64'(b0.bank_htu_valid_o), 4'b0010);
    chk("bp_reload_addr",
        64'(b0.bank_htu_addr_o[1*AW +: AW]), 9);
    chk("bp_reload_op",
        64'(b0.bank_htu_opcode_o[1*OW +: OW]), 6);
    tick();
    chk("bp_drain", 64'(b0.bank_htu_valid_o), 0);

    // reset mid-operation with all slots full
    b0.bank_htu_ready_i = 4'h0;
    drv(0, 1'b1, 28'h0, 3'd0);
    drv(1, 1'b1, 28'h1, 3'd0);
    drv(2, 1'b1, 28'h2, 3'd0);
    #1;
    tick();
    drv(0, 1'b1, 28'h3, 3'd0);
    drv(1, 1'b0, 28'h0, 3'd0);
    drv(2, 1'b0, 28'h0, 3'd0);
    tick();
    chk("mid_full", 64'(b0.bank_htu_valid_o), 4'hF);
    drv(0, 1'b1, 28'h1, 3'd1);
    drv(1, 1'b1, 28'h1, 3'd2);
    drv(2, 1'b1, 28'h1, 3'd3);
    #1;
    chk("mid_blocked", 64'(b0.ch_req_allowIn_o), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(b0.bank_htu_valid_o), 0);
    chk("mid_rst_allow", 64'(b0.ch_req_allowIn_o), 0);
    chk("mid_rst_id", 64'(b0.bank_htu_ch_id_o), 0);
    chk("mid_rst_addr1",
        64'(b0.bank_htu_addr_o[1*AW +: AW]), 0);
    tick();
    rst_n = 1'b1;
    b0.bank_htu_ready_i = 4'hF;
    #1;
    chk("mid_first_allow", 64'(b0.ch_req_allowIn_o), 3'b001);
    tick();
    idle_all();
    chk("mid_first_v", 64'(b0.bank_htu_valid_o), 4'b0010);
    chk("mid_first_id",
        64'(b0.bank_htu_ch_id_o[1*CW +: CW]), 0);
    chk("mid_first_addr",
        64'(b0.bank_htu_addr_o[1*AW +: AW]), 1);

    // hash vs plain decode
    b1.ch_req_valid_i[0]     = 1'b1;
    b1.ch_req_addr_i[0 +: AW] = 28'h5;
    drv(0, 1'b1, 28'h5, 3'd0);
    #1;
    chk("h5_allow_h", 64'(b1.ch_req_allowIn_o), 3'b001);
    chk("h5_allow_p", 64'(b0.ch_req_allowIn_o), 3'b001);
    tick();
    chk("h5_bank_h", 64'(b1.bank_htu_valid_o), 4'b0001);
    chk("h5_bank_p", 64'(b0.bank_htu_valid_o), 4'b0010);
    b1.ch_req_addr_i[0 +: AW] = 28'h6;
    drv(0, 1'b1, 28'h6, 3'd0);
    tick();
    b1.ch_req_valid_i = '0;
    idle_all();
    chk("h6_bank_h", 64'(b1.bank_htu_valid_o), 4'b1000);
    chk("h6_bank_p", 64'(b0.bank_htu_valid_o), 4'b0100);
    chk("h6_addr_h",
        64'(b1.bank_htu_addr_o[3*AW +: AW]), 6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
